// File: rtl/led_nios_copier_pkg.sv
// Shared types and default widths for the Nios word-copy Avalon-MM master.
package led_nios_copier_pkg;

   localparam int ADDR_W_DEF = 13;
   localparam int DATA_W_DEF = 32;
   localparam int LEN_W_DEF  = 13;

   localparam logic [DATA_W_DEF/8-1:0] BE_ALL = '1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      FINISH  = 3'd4
   } state_e;

endpackage

// File: rtl/led_nios_mem_copier.sv
// Avalon-MM master copying a block of words one at a time: read, wait for data, write.
module led_nios_mem_copier
   import led_nios_copier_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   src_addr,
   input  logic [ADDR_W-1:0]   dst_addr,
   input  logic [LEN_W-1:0]    length,
   output logic                busy,
   output logic                done,
   output logic [LEN_W-1:0]    words_done,
   output logic [ADDR_W-1:0]   avm_address,
   output logic                avm_read,
   output logic                avm_write,
   output logic [DATA_W-1:0]   avm_writedata,
   output logic [DATA_W/8-1:0] avm_byteenable,
   input  logic [DATA_W-1:0]   avm_readdata,
   input  logic                avm_readdatavalid,
   input  logic                avm_waitrequest
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   src_q, src_d;
   logic [ADDR_W-1:0]   dst_q, dst_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic [LEN_W-1:0]    cnt_inc;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                busy_q, done_q, rd_q, wr_q;

   assign cnt_inc = cnt_q + 1'b1;

   // NOTE: every signal assigned here gets a default first, so no path leaves a latch.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      data_d  = data_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d = '0;
               if (length != '0) begin
                  src_d   = src_addr;
                  dst_d   = dst_addr;
                  len_d   = length;
                  state_d = RD_REQ;
               end else begin
                  state_d = FINISH;
               end
            end
         end
         RD_REQ: begin
            if (!avm_waitrequest) begin
               src_d   = src_q + 1'b1;
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (avm_readdatavalid) begin
               data_d  = avm_readdata;
               state_d = WR_REQ;
            end
         end
         WR_REQ: begin
            if (!avm_waitrequest) begin
               dst_d   = dst_q + 1'b1;
               cnt_d   = cnt_inc;
               state_d = (cnt_inc == len_q) ? FINISH : RD_REQ;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The bus address is loaded from whichever pointer the next request uses,
   // so it stays frozen while a request is stalled.
   always_comb begin
      addr_d = addr_q;
      if (state_d == RD_REQ)
         addr_d = src_d;
      else if (state_d == WR_REQ)
         addr_d = dst_d;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         busy_q  <= (state_d == RD_REQ) || (state_d == RD_WAIT) || (state_d == WR_REQ);
         done_q  <= (state_d == FINISH);
         rd_q    <= (state_d == RD_REQ);
         wr_q    <= (state_d == WR_REQ);
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign words_done     = cnt_q;
   assign avm_address    = addr_q;
   assign avm_read       = rd_q;
   assign avm_write      = wr_q;
   assign avm_writedata  = data_q;
   assign avm_byteenable = {(DATA_W/8){1'b1}};

endmodule

// File: tb/tb_led_nios_mem_copier.sv
// Randomised scoreboard bench: memory slave model, sequential copy reference, bus monitor.
module tb_led_nios_mem_copier;

   localparam int AW = 13;
   localparam int DW = 32;
   localparam int LW = 13;
   localparam int MEM_WORDS = 1 << AW;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } resp_t;

   logic            clk;
   logic            reset_n;
   logic            start;
   logic [AW-1:0]   src_addr;
   logic [AW-1:0]   dst_addr;
   logic [LW-1:0]   length;
   logic            busy;
   logic            done;
   logic [LW-1:0]   words_done;
   logic [AW-1:0]   avm_address;
   logic            avm_read;
   logic            avm_write;
   logic [DW-1:0]   avm_writedata;
   logic [DW/8-1:0] avm_byteenable;
   logic [DW-1:0]   avm_readdata;
   logic            avm_readdatavalid;
   logic            avm_waitrequest;

   led_nios_mem_copier dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .start             (start),
      .src_addr          (src_addr),
      .dst_addr          (dst_addr),
      .length            (length),
      .busy              (busy),
      .done              (done),
      .words_done        (words_done),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_write         (avm_write),
      .avm_writedata     (avm_writedata),
      .avm_byteenable    (avm_byteenable),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .avm_waitrequest   (avm_waitrequest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] mem    [MEM_WORDS];
   logic [DW-1:0] shadow [MEM_WORDS];

   logic [AW-1:0] exp_rd[$];
   wr_t           exp_wr[$];
   int            exp_done[$];
   resp_t         pend[$];

   int ws_cfg  = 0;
   int lat_cfg = 1;
   int ncyc    = 0;
   int stall   = 0;
   int rd_cnt  = 0;
   int wr_cnt  = 0;
   int proto_err = 0;
   bit busy_seen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Memory slave: fixed wait states per request, fixed read latency, stray data valids.
   always @(negedge clk) begin
      ncyc++;
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      if (pend.size() != 0 && pend[0].due == ncyc) begin
         avm_readdatavalid = 1'b1;
         avm_readdata      = pend[0].data;
         void'(pend.pop_front());
      end else if (pend.size() == 0 && $urandom_range(0, 5) == 0) begin
         avm_readdatavalid = 1'b1;
      end

      if (!reset_n) begin
         stall           = 0;
         avm_waitrequest = 1'b0;
      end else if (avm_read || avm_write) begin
         if (stall < ws_cfg) begin
            avm_waitrequest = 1'b1;
            stall++;
         end else begin
            avm_waitrequest = 1'b0;
            stall = 0;
            if (avm_write)
               mem[avm_address] = avm_writedata;
            else
               pend.push_back('{data: mem[avm_address], due: ncyc + lat_cfg});
         end
      end else begin
         avm_waitrequest = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: pops expected transactions as the DUT completes them.
   logic [AW-1:0] h_addr;
   logic [DW-1:0] h_data;
   logic          h_rd, h_wr;
   bit            h_valid = 0;

   always @(negedge clk) begin
      #1;
      if (!reset_n) begin
         h_valid = 0;
      end else begin
         if (avm_read && avm_write) proto_err++;
         if (h_valid && (avm_address !== h_addr || avm_read !== h_rd || avm_write !== h_wr ||
                         (h_wr && avm_writedata !== h_data)))
            proto_err++;
         h_valid = (avm_read || avm_write) && avm_waitrequest;
         h_addr  = avm_address;
         h_data  = avm_writedata;
         h_rd    = avm_read;
         h_wr    = avm_write;
         if (busy) busy_seen = 1;

         if (avm_read && !avm_waitrequest) begin
            rd_cnt++;
            check("rd_expected", 64'(exp_rd.size() != 0), 1);
            if (exp_rd.size() != 0) check("rd_addr", avm_address, exp_rd.pop_front());
         end
         if (avm_write && !avm_waitrequest) begin
            wr_cnt++;
            check("wr_expected", 64'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) begin
               wr_t e;
               e = exp_wr.pop_front();
               check("wr_addr", avm_address, e.addr);
               check("wr_data", avm_writedata, e.data);
            end
         end
         if (done) begin
            check("done_expected", 64'(exp_done.size() != 0), 1);
            if (exp_done.size() != 0) begin
               int w;
               w = exp_done.pop_front();
               if (w >= 0) check("words_done", words_done, w);
            end
         end
      end
   end

   // Reference: the copy proceeds word by word in order, so later reads see earlier writes.
   task automatic model_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n);
      for (int i = 0; i < int'(n); i++) begin
         logic [AW-1:0] a, b;
         a = s + AW'(i);
         b = d + AW'(i);
         exp_rd.push_back(a);
         shadow[b] = shadow[a];
         exp_wr.push_back('{addr: b, data: shadow[b]});
      end
   endtask

   task automatic run_cmd(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n,
                          input int ws, input int lat, input bit poke);
      int  exp_cyc, k, rd0, wr0;
      bit  seen;
      ws_cfg  = ws;
      lat_cfg = lat;
      model_copy(s, d, n);
      exp_done.push_back(n == 0 ? -1 : int'(n));
      exp_cyc = (n == 0) ? 1 : 1 + int'(n) * (3 + 2 * ws + lat - 1);
      rd0 = rd_cnt;
      wr0 = wr_cnt;

      @(negedge clk);
      start = 1'b1; src_addr = s; dst_addr = d; length = n;
      busy_seen = 0;
      @(negedge clk);
      start = 1'b0; src_addr = $urandom; dst_addr = $urandom; length = $urandom;

      k = 1;
      seen = 0;
      while (!seen && k <= exp_cyc + 64) begin
         if (k == 1 && n != 0) begin
            check("busy_rise", busy, 1);
            check("read_rise", avm_read, 1);
         end
         if (done) begin
            seen = 1;
         end else begin
            start = (poke && k == 4);
            if (poke && k == 4) begin
               src_addr = s + 13'h055;
               dst_addr = d + 13'h077;
               length   = n + 13'd3;
            end
            @(negedge clk);
            k++;
         end
      end
      start = 1'b0;

      check("done_seen", seen, 1);
      check("done_cycle", k, exp_cyc);
      check("busy_low_at_done", busy, 0);
      check("reads_issued", rd_cnt - rd0, n);
      check("writes_issued", wr_cnt - wr0, n);
      if (n == 0) check("zero_len_busy", busy_seen, 0);
      if (!seen) begin
         exp_rd.delete();
         exp_wr.delete();
         exp_done.delete();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_read"}, avm_read, 0);
      check({tag, "_write"}, avm_write, 0);
      check({tag, "_addr"}, avm_address, 0);
      check({tag, "_wdata"}, avm_writedata, 0);
      check({tag, "_words"}, words_done, 0);
      check({tag, "_be"}, avm_byteenable, 4'hF);
   endtask

   task automatic reset_mid_copy();
      int base, k, wbase, rbase;
      ws_cfg  = 0;
      lat_cfg = 4;
      model_copy(13'h0400, 13'h0500, 13'd4);
      exp_done.push_back(4);
      base = rd_cnt;
      @(negedge clk);
      start = 1'b1; src_addr = 13'h0400; dst_addr = 13'h0500; length = 13'd4;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (rd_cnt < base + 2 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("rst_reached_rd2", rd_cnt - base, 2);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      exp_rd.delete();
      exp_wr.delete();
      exp_done.delete();
      wbase = wr_cnt;
      rbase = rd_cnt;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      check("late_rdv_delivered", pend.size(), 0);
      check("rst_no_write", wr_cnt - wbase, 0);
      check("rst_no_read", rd_cnt - rbase, 0);
      check("rst_idle_busy", busy, 0);
      check("rst_idle_wdata", avm_writedata, 0);
      for (int i = 0; i < MEM_WORDS; i++) shadow[i] = mem[i];
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      length   = '0;
      avm_readdata      = '0;
      avm_readdatavalid = 1'b0;
      avm_waitrequest   = 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) begin
         mem[i]    = $urandom;
         shadow[i] = mem[i];
      end
      for (int i = 0; i < 4; i++) begin
         mem[i]    = 32'hA0 + 32'(i);
         shadow[i] = mem[i];
      end

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      run_cmd(13'h0000, 13'h0100, 13'd4, 0, 1, 0);
      for (int i = 0; i < 4; i++) check("basic_mem", mem[256 + i], 32'hA0 + 32'(i));

      run_cmd(13'h0020, 13'h0040, 13'd2, 2, 1, 0);
      run_cmd(13'h0005, 13'h0006, 13'd0, 0, 1, 0);
      run_cmd(13'h1FFE, 13'h0010, 13'd4, 0, 1, 0);
      for (int i = 0; i < 4; i++) check("wrap_mem", mem[16 + i], shadow[16 + i]);

      run_cmd(13'h0200, 13'h0300, 13'd6, 1, 2, 1);
      reset_mid_copy();
      run_cmd(13'h0400, 13'h0500, 13'd4, 0, 1, 0);

      for (int t = 0; t < 12; t++) begin
         run_cmd(AW'($urandom), AW'($urandom), LW'($urandom_range(0, 8)),
                 $urandom_range(0, 2), $urandom_range(1, 3), bit'($urandom_range(0, 1)));
      end

      repeat (4) @(negedge clk);
      check("protocol_errors", proto_err, 0);
      check("exp_rd_drained", exp_rd.size(), 0);
      check("exp_wr_drained", exp_wr.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/led_nios_mem_copier.md
# led_nios_mem_copier

Avalon-MM master that copies a block of 32-bit words from one word address range to another. It moves one word at a time and sits on the Nios system interconnect opposite the on-chip memory slave (single-port, 13-bit word address, byte enables, fixed read latency). The Nios CPU, or a small control FSM, issues a start command with source, destination and length. The block reports busy, a done pulse and a running word count.

## Interface
- ADDR_W, 13, word-address width of the Avalon master port
- DATA_W, 32, data width; byteenable width is DATA_W/8
- LEN_W, 13, width of length and word-count fields
- clk  in  1  system clock; sole clock domain
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- src_addr  in  ADDR_W  first source word address
- dst_addr  in  ADDR_W  first destination word address
- length  in  LEN_W  number of words to copy; 0 is legal
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at completion
- words_done  out  LEN_W  words written so far in the current or last command
- avm_address  out  ADDR_W  word address
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_writedata  out  DATA_W  write data
- avm_byteenable  out  DATA_W/8  always all ones
- avm_readdata  in  DATA_W  read data
- avm_readdatavalid  in  1  read data qualifier; latency ≥1 cycle
- avm_waitrequest  in  1  slave stall; holds the current request

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH.
- IDLE:
  - start=1 and length≠0: latch src_addr, dst_addr and length; clear words_done; go to RD_REQ.
  - start=1 and length=0: go to FINISH. No bus cycle is issued.
- RD_REQ: avm_read=1, avm_address=src pointer.
  - waitrequest=1: hold.
  - waitrequest=0: request accepted. Increment src pointer; go to RD_WAIT.
- RD_WAIT: no request asserted. On readdatavalid=1, capture avm_readdata into the data register and go to WR_REQ.
- WR_REQ: avm_write=1, avm_address=dst pointer, avm_writedata=data register.
  - waitrequest=1: hold.
  - waitrequest=0: increment dst pointer and words_done. If words_done+1 = length, go to FINISH; otherwise go to RD_REQ.
- FINISH: done=1 for one cycle; go to IDLE.
- Pointers wrap modulo 2^ADDR_W with no error flag.
- start is ignored while busy. Command inputs are only sampled on an accepted start.
- avm_read and avm_write are never high together. Address and data stay stable while waitrequest=1.
- An unexpected readdatavalid outside RD_WAIT is ignored.
- Reset mid-operation abandons the transfer. An outstanding read response arriving after reset is ignored because the FSM is in IDLE.

## Timing
- Reset values:
  - State IDLE.
  - busy, done, avm_read, avm_write: 0.
  - avm_address, avm_writedata, words_done: 0.
  - avm_byteenable: all ones.
- All outputs are registered.
- Start accepted at edge t: busy=1 and avm_read=1 from t+1.
- With zero wait states and read latency 1, each word takes 3 cycles (RD_REQ, RD_WAIT, WR_REQ).
- An N-word copy asserts done at cycle t+1+3N, with busy falling in the same cycle as done.
- Each waitrequest cycle adds one cycle. Each extra read-latency cycle adds one cycle.
- length=0: done at t+1; busy stays 0.
- A new start is accepted in the cycle after done (IDLE).

## Structure
- Shared package led_nios_copier_pkg holds:
  - the state enum {IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH};
  - default ADDR_W, DATA_W and LEN_W constants;
  - BE_ALL = all-ones byteenable.
- Single module: FSM, pointer/count registers and data register in one file. No sub-module is warranted.

## Test plan
- Copy, no stalls, latency 1: mem[0..3]=0xA0..0xA3, src=0, dst=0x100, len=4 → mem[0x100..0x103]=0xA0..0xA3, done 13 cycles after start, words_done=4.
- Backpressure: waitrequest high for 2 cycles on every read and write, len=2 → data correct, address/data stable during stalls, done at start+1+6+8.
- Zero length: len=0 → no avm_read/avm_write, done pulse at start+1, busy never high.
- Wrap: src=0x1FFE, dst=0x0010, len=4 → reads 0x1FFE, 0x1FFF, 0x0000, 0x0001 in order; writes to 0x10..0x13.
- Start while busy: second start with different src mid-copy → ignored; the first copy completes unchanged.
- Reset mid-copy: reset_n low during RD_WAIT of word 2, then a late readdatavalid → all outputs at reset values, no write issued, next start runs normally.
